mips_multicycle_control: RTL and testbench
==========================================

Name: mips_multicycle_control

Overview:
Moore-style FSM that sequences the shared MIPS datapath in multi-cycle mode. It drives the select lines of the datapath muxes: RegDst (write-register 5-bit mux), ALUSrcA/ALUSrcB (ALU operand muxes), MemtoReg, IorD and PCSource (32-bit muxes). It also drives the register-file, IR, PC and memory enables. It sits between the instruction register (opcode), the ALU (zero flag) and a variable-latency memory (mem_ready).

Parameters:
CNT_W, 16, width of retired-instruction counter
USE_MEM_READY, 1, 1 = honour mem_ready stalls; 0 = treat mem_ready as constant 1

Ports:
clock  in  1  single system clock, rising edge
reset_n  in  1  reset, synchronous, active-low
opcode  in  6  IR[31:26]; stable from DECODE until instruction completes
zero  in  1  ALU zero flag
mem_ready  in  1  memory access complete this cycle
RegDst  out  1  1 = rd, 0 = rt
ALUSrcA  out  1  0 = PC, 1 = reg A
ALUSrcB  out  2  00 = reg B, 01 = const 4, 10 = signext, 11 = signext<<2
ALUOp  out  2  00 = add, 01 = sub, 10 = use funct
MemtoReg  out  1  1 = MDR, 0 = ALUOut
RegWrite, MemRead, MemWrite, IRWrite  out  1 each  enables
IorD  out  1  0 = PC address, 1 = ALUOut address
PCSource  out  2  00 = ALU result, 01 = ALUOut, 10 = jump target
pc_en  out  1  PCWrite | (PCWriteCond & zero)
instr_done  out  1  one-cycle pulse when an instruction completes
illegal_op  out  1  unsupported opcode seen in DECODE
retired  out  CNT_W  completed-instruction count
state  out  4  current state encoding, for debug

Behaviour:
- Reset: when reset_n=0 at a rising edge, the next state is IDLE and retired=0. In IDLE, every control output is 0. IDLE always goes to FETCH on the next cycle.
- Encodings: IDLE 0, FETCH 1, DECODE 2, MEMADDR 3, MEMREAD 4, MEMWB 5, MEMWRITE 6, EXECUTE 7, RTYPE_WB 8, BRANCH 9, JUMP 10, ADDI_EX 11, ADDI_WB 12.
- Outputs are decoded from the state only, except the mem_ready gating noted below and illegal_op. Unlisted outputs are 0.
- FETCH: MemRead=1, IorD=0, ALUSrcA=0, ALUSrcB=01, ALUOp=00, PCSource=00, IRWrite=PCWrite=mem_ready. Stays in FETCH while mem_ready=0; goes to DECODE when mem_ready=1.
- DECODE: ALUSrcA=0, ALUSrcB=11, ALUOp=00. Next state by opcode:
  - 100011 or 101011 -> MEMADDR
  - 000000 -> EXECUTE
  - 000100 -> BRANCH
  - 000010 -> JUMP
  - 001000 -> ADDI_EX
  - any other opcode -> FETCH, with illegal_op=1 for that cycle and no instr_done.
- MEMADDR: ALUSrcA=1, ALUSrcB=10, ALUOp=00. Goes to MEMREAD if opcode=100011, otherwise to MEMWRITE.
- MEMREAD: MemRead=1, IorD=1. Waits for mem_ready, then goes to MEMWB.
- MEMWB: RegDst=0, MemtoReg=1, RegWrite=1, instr_done=1. Goes to FETCH.
- MEMWRITE: IorD=1, MemWrite=1. Waits for mem_ready; on the ready cycle instr_done=1 and the next state is FETCH.
- EXECUTE: ALUSrcA=1, ALUSrcB=00, ALUOp=10. Goes to RTYPE_WB.
- RTYPE_WB: RegDst=1, MemtoReg=0, RegWrite=1, instr_done=1. Goes to FETCH.
- BRANCH: ALUSrcA=1, ALUSrcB=00, ALUOp=01, PCWriteCond=1, PCSource=01, instr_done=1. Goes to FETCH. pc_en equals zero.
- JUMP: PCWrite=1, PCSource=10, instr_done=1. Goes to FETCH.
- ADDI_EX: ALUSrcA=1, ALUSrcB=10, ALUOp=00. Goes to ADDI_WB.
- ADDI_WB: RegDst=0, MemtoReg=0, RegWrite=1, instr_done=1. Goes to FETCH.
- Latency with no stalls: lw 5 cycles; sw, R-type and addi 4 cycles; beq and j 3 cycles. Each stalled cycle adds 1.
- retired increments on each cycle where instr_done=1. It wraps from all-ones to 0.
- Reset takes priority over all transitions, including mid-instruction and mid-stall. The aborted instruction does not count and produces no further writes.
- An unknown or invalid state register value goes to IDLE on the next edge, with all outputs 0.
- MemRead and MemWrite are never both 1. RegWrite is never 1 in the same cycle as MemWrite.

Test Plan:
- Reset then lw (100011), mem_ready=1 constantly -> states 0,1,2,3,4,5,1. RegWrite=MemtoReg=1 only in MEMWB. retired=1.
- R-type (000000) -> EXECUTE drives ALUOp=10, ALUSrcB=00. RTYPE_WB drives RegDst=1, RegWrite=1. 4 cycles FETCH-to-FETCH.
- beq with zero=1, then beq with zero=0 -> pc_en=1 in BRANCH for the first and 0 for the second. PCSource=01 in both. retired advances by 2.
- sw with mem_ready held low 3 cycles in MEMWRITE -> MemWrite held high 4 cycles. instr_done pulses only on the ready cycle.
- opcode 111111 -> illegal_op=1 for one DECODE cycle, returns to FETCH, retired unchanged.
- reset_n=0 asserted in MEMREAD -> next cycle IDLE with all outputs 0 and retired=0. With CNT_W=4, 16 instructions -> retired wraps to 0.

Source files
------------

// File: rtl/mips_multicycle_control.sv
// Multi-cycle MIPS control FSM: sequences the shared datapath.
// Moore outputs per state; memory stalls gate IRWrite/PCWrite/instr_done.
module mips_multicycle_control #(
  parameter int CNT_W         = 16,
  parameter bit USE_MEM_READY = 1'b1
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic [5:0]       opcode,
  input  logic             zero,
  input  logic             mem_ready,
  output logic             RegDst,
  output logic             ALUSrcA,
  output logic [1:0]       ALUSrcB,
  output logic [1:0]       ALUOp,
  output logic             MemtoReg,
  output logic             RegWrite,
  output logic             MemRead,
  output logic             MemWrite,
  output logic             IRWrite,
  output logic             IorD,
  output logic [1:0]       PCSource,
  output logic             pc_en,
  output logic             instr_done,
  output logic             illegal_op,
  output logic [CNT_W-1:0] retired,
  output logic [3:0]       state
);

  typedef enum logic [3:0] {
    S_IDLE     = 4'd0,
    S_FETCH    = 4'd1,
    S_DECODE   = 4'd2,
    S_MEMADDR  = 4'd3,
    S_MEMREAD  = 4'd4,
    S_MEMWB    = 4'd5,
    S_MEMWRITE = 4'd6,
    S_EXECUTE  = 4'd7,
    S_RTYPE_WB = 4'd8,
    S_BRANCH   = 4'd9,
    S_JUMP     = 4'd10,
    S_ADDI_EX  = 4'd11,
    S_ADDI_WB  = 4'd12
  } state_e;

  localparam logic [5:0] OP_LW   = 6'b100011;
  localparam logic [5:0] OP_SW   = 6'b101011;
  localparam logic [5:0] OP_RT   = 6'b000000;
  localparam logic [5:0] OP_BEQ  = 6'b000100;
  localparam logic [5:0] OP_J    = 6'b000010;
  localparam logic [5:0] OP_ADDI = 6'b001000;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] retired_q;
  logic             rdy;
  logic             pc_write;
  logic             pc_write_cond;

  assign rdy = USE_MEM_READY ? mem_ready : 1'b1;

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state_q   <= S_IDLE;
      retired_q <= '0;
    end else begin
      state_q <= state_d;
      if (instr_done)
        retired_q <= retired_q + CNT_W'(1);
    end
  end

  always_comb begin
    state_d       = S_IDLE;
    RegDst        = 1'b0;
    ALUSrcA       = 1'b0;
    ALUSrcB       = 2'b00;
    ALUOp         = 2'b00;
    MemtoReg      = 1'b0;
    RegWrite      = 1'b0;
    MemRead       = 1'b0;
    MemWrite      = 1'b0;
    IRWrite       = 1'b0;
    IorD          = 1'b0;
    PCSource      = 2'b00;
    pc_write      = 1'b0;
    pc_write_cond = 1'b0;
    instr_done    = 1'b0;
    illegal_op    = 1'b0;
    case (state_q)
      S_IDLE: state_d = S_FETCH;
      S_FETCH: begin
        MemRead  = 1'b1;
        ALUSrcB  = 2'b01;
        IRWrite  = rdy;
        pc_write = rdy;
        state_d  = rdy ? S_DECODE : S_FETCH;
      end
      S_DECODE: begin
        ALUSrcB = 2'b11;
        case (opcode)
          OP_LW, OP_SW: state_d = S_MEMADDR;
          OP_RT:        state_d = S_EXECUTE;
          OP_BEQ:       state_d = S_BRANCH;
          OP_J:         state_d = S_JUMP;
          OP_ADDI:      state_d = S_ADDI_EX;
          default: begin
            illegal_op = 1'b1;
            state_d    = S_FETCH;
          end
        endcase
      end
      S_MEMADDR: begin
        ALUSrcA = 1'b1;
        ALUSrcB = 2'b10;
        state_d = (opcode == OP_LW) ? S_MEMREAD : S_MEMWRITE;
      end
      S_MEMREAD: begin
        MemRead = 1'b1;
        IorD    = 1'b1;
        state_d = rdy ? S_MEMWB : S_MEMREAD;
      end
      S_MEMWB: begin
        MemtoReg   = 1'b1;
        RegWrite   = 1'b1;
        instr_done = 1'b1;
        state_d    = S_FETCH;
      end
      S_MEMWRITE: begin
        IorD       = 1'b1;
        MemWrite   = 1'b1;
        instr_done = rdy;
        state_d    = rdy ? S_FETCH : S_MEMWRITE;
      end
      S_EXECUTE: begin
        ALUSrcA = 1'b1;
        ALUOp   = 2'b10;
        state_d = S_RTYPE_WB;
      end
      S_RTYPE_WB: begin
        RegDst     = 1'b1;
        RegWrite   = 1'b1;
        instr_done = 1'b1;
        state_d    = S_FETCH;
      end
      S_BRANCH: begin
        ALUSrcA       = 1'b1;
        ALUOp         = 2'b01;
        PCSource      = 2'b01;
        pc_write_cond = 1'b1;
        instr_done    = 1'b1;
        state_d       = S_FETCH;
      end
      S_JUMP: begin
        PCSource   = 2'b10;
        pc_write   = 1'b1;
        instr_done = 1'b1;
        state_d    = S_FETCH;
      end
      S_ADDI_EX: begin
        ALUSrcA = 1'b1;
        ALUSrcB = 2'b10;
        state_d = S_ADDI_WB;
      end
      S_ADDI_WB: begin
        RegWrite   = 1'b1;
        instr_done = 1'b1;
        state_d    = S_FETCH;
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign pc_en   = pc_write | (pc_write_cond & zero);
  assign retired = retired_q;
  assign state   = state_q;

endmodule

// File: tb/tb_mips_multicycle_control.sv
// Bench for mips_multicycle_control: random instruction streams
// checked against a per-instruction cycle-trace model.
module tb_mips_multicycle_control;

  localparam int CW = 4;

  logic          clock = 1'b0;
  logic          reset_n;
  logic [5:0]    opcode;
  logic          zero;
  logic          mem_ready;
  logic          RegDst, ALUSrcA, MemtoReg, RegWrite;
  logic          MemRead, MemWrite, IRWrite, IorD;
  logic [1:0]    ALUSrcB, ALUOp, PCSource;
  logic          pc_en, instr_done, illegal_op;
  logic [CW-1:0] retired;
  logic [3:0]    state;

  int            n_chk = 0;
  int            n_err = 0;
  logic [CW-1:0] ret_m = '0;

  mips_multicycle_control #(.CNT_W(CW), .USE_MEM_READY(1'b1)) dut (
    .clock(clock), .reset_n(reset_n), .opcode(opcode),
    .zero(zero), .mem_ready(mem_ready),
    .RegDst(RegDst), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB),
    .ALUOp(ALUOp), .MemtoReg(MemtoReg), .RegWrite(RegWrite),
    .MemRead(MemRead), .MemWrite(MemWrite), .IRWrite(IRWrite),
    .IorD(IorD), .PCSource(PCSource), .pc_en(pc_en),
    .instr_done(instr_done), .illegal_op(illegal_op),
    .retired(retired), .state(state)
  );

  always #5 clock = ~clock;

  wire [15:0] ctl_o = {RegDst, ALUSrcA, ALUSrcB, ALUOp, MemtoReg,
                       RegWrite, MemRead, MemWrite, IRWrite, IorD,
                       PCSource, instr_done, illegal_op};

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s got %h want %h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic logic [15:0] cv(
    input logic rd, input logic sa, input logic [1:0] sb,
    input logic [1:0] op, input logic m2r, input logic rw,
    input logic mr, input logic mw, input logic irw,
    input logic iord, input logic [1:0] pcs,
    input logic done, input logic ill);
    return {rd, sa, sb, op, m2r, rw, mr, mw, irw, iord, pcs, done, ill};
  endfunction

  // One cycle: apply inputs, compare, then advance the retired model.
  task automatic cyc(input logic [3:0] st, input logic [15:0] v,
                     input logic pcw, input logic pcwc,
                     input logic rdy, input logic z);
    mem_ready = rdy;
    zero      = z;
    #1;
    chk("state", 32'(state), 32'(st));
    chk("ctl", 32'(ctl_o), 32'(v));
    chk("pc_en", 32'(pc_en), 32'(pcw | (pcwc & z)));
    chk("retired", 32'(retired), 32'(ret_m));
    @(posedge clock);
    if (!reset_n) ret_m = '0;
    else if (v[1]) ret_m = ret_m + 1'b1;
    @(negedge clock);
  endtask

  function automatic logic rb();
    return 1'($urandom_range(0, 1));
  endfunction

  task automatic fetch(input int stall);
    for (int i = 0; i < stall; i++)
      cyc(4'd1, cv(0,0,2'b01,2'b00,0,0,1,0,0,0,2'b00,0,0), 0, 0, 0, rb());
    cyc(4'd1, cv(0,0,2'b01,2'b00,0,0,1,0,1,0,2'b00,0,0), 1, 0, 1, rb());
  endtask

  task automatic run_instr(input logic [5:0] op, input logic zb,
                           input int fst, input int mst);
    bit legal;
    legal = (op == 6'h23) || (op == 6'h2B) || (op == 6'h00) ||
            (op == 6'h04) || (op == 6'h02) || (op == 6'h08);
    opcode = op;
    fetch(fst);
    cyc(4'd2, cv(0,0,2'b11,2'b00,0,0,0,0,0,0,2'b00,0,!legal),
        0, 0, rb(), rb());
    if (!legal) return;
    case (op)
      6'h23, 6'h2B: begin
        cyc(4'd3, cv(0,1,2'b10,2'b00,0,0,0,0,0,0,2'b00,0,0),
            0, 0, rb(), rb());
        if (op == 6'h23) begin
          for (int i = 0; i < mst; i++)
            cyc(4'd4, cv(0,0,2'b00,2'b00,0,0,1,0,0,1,2'b00,0,0),
                0, 0, 0, rb());
          cyc(4'd4, cv(0,0,2'b00,2'b00,0,0,1,0,0,1,2'b00,0,0),
              0, 0, 1, rb());
          cyc(4'd5, cv(0,0,2'b00,2'b00,1,1,0,0,0,0,2'b00,1,0),
              0, 0, rb(), rb());
        end else begin
          for (int i = 0; i < mst; i++)
            cyc(4'd6, cv(0,0,2'b00,2'b00,0,0,0,1,0,1,2'b00,0,0),
                0, 0, 0, rb());
          cyc(4'd6, cv(0,0,2'b00,2'b00,0,0,0,1,0,1,2'b00,1,0),
              0, 0, 1, rb());
        end
      end
      6'h00: begin
        cyc(4'd7, cv(0,1,2'b00,2'b10,0,0,0,0,0,0,2'b00,0,0),
            0, 0, rb(), rb());
        cyc(4'd8, cv(1,0,2'b00,2'b00,0,1,0,0,0,0,2'b00,1,0),
            0, 0, rb(), rb());
      end
      6'h04:
        cyc(4'd9, cv(0,1,2'b00,2'b01,0,0,0,0,0,0,2'b01,1,0),
            0, 1, rb(), zb);
      6'h02:
        cyc(4'd10, cv(0,0,2'b00,2'b00,0,0,0,0,0,0,2'b10,1,0),
            1, 0, rb(), rb());
      default: begin
        cyc(4'd11, cv(0,1,2'b10,2'b00,0,0,0,0,0,0,2'b00,0,0),
            0, 0, rb(), rb());
        cyc(4'd12, cv(0,0,2'b00,2'b00,0,1,0,0,0,0,2'b00,1,0),
            0, 0, rb(), rb());
      end
    endcase
  endtask

  task automatic do_reset();
    reset_n   = 1'b0;
    mem_ready = 1'b0;
    zero      = 1'b0;
    @(posedge clock);
    @(posedge clock);
    @(negedge clock);
    ret_m   = '0;
    reset_n = 1'b1;
    cyc(4'd0, 16'h0, 0, 0, rb(), rb());
  endtask

  function automatic logic [5:0] rand_op();
    logic [5:0] ops [6] = '{6'h23, 6'h2B, 6'h00, 6'h04, 6'h02, 6'h08};
    int k;
    k = $urandom_range(0, 6);
    return (k == 6) ? 6'($urandom) : ops[k];
  endfunction

  initial begin
    opcode = 6'h00;
    do_reset();

    run_instr(6'h23, 0, 0, 0);
    chk("lw_retired", 32'(retired), 32'd1);
    run_instr(6'h00, 0, 0, 0);
    run_instr(6'h04, 1, 0, 0);
    run_instr(6'h04, 0, 0, 0);
    chk("beq_retired", 32'(retired), 32'd4);
    run_instr(6'h2B, 0, 1, 3);
    run_instr(6'h3F, 0, 0, 0);
    chk("illegal_retired", 32'(retired), 32'd5);
    run_instr(6'h02, 0, 2, 0);
    run_instr(6'h08, 0, 0, 0);

    // Abort a load while it waits in MEMREAD.
    opcode = 6'h23;
    fetch(0);
    cyc(4'd2, cv(0,0,2'b11,2'b00,0,0,0,0,0,0,2'b00,0,0), 0, 0, 1, 0);
    cyc(4'd3, cv(0,1,2'b10,2'b00,0,0,0,0,0,0,2'b00,0,0), 0, 0, 1, 0);
    reset_n = 1'b0;
    cyc(4'd4, cv(0,0,2'b00,2'b00,0,0,1,0,0,1,2'b00,0,0), 0, 0, 0, 0);
    reset_n = 1'b1;
    cyc(4'd0, 16'h0, 0, 0, 1, 1);
    chk("abort_retired", 32'(retired), 32'd0);

    for (int i = 0; i < 16; i++)
      run_instr(6'h02, 0, 0, 0);
    chk("wrap", 32'(retired), 32'd0);

    for (int i = 0; i < 300; i++)
      run_instr(rand_op(), rb(), $urandom_range(0, 2),
                $urandom_range(0, 3));

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule
